dataframe_sequencer: RTL and testbench
======================================

DATAFRAME_SEQUENCER -- requirements
Module: dataframe_sequencer

Interface
REQ-001 The block SHALL have parameter LEN_MSB, default 175, meaning the MSB of the 12-bit frame-length field in HF_FIFO_DOUT.
REQ-002 The block SHALL have parameter LEN_LSB, default 164, meaning the LSB of the frame-length field; LEN_MSB-LEN_LSB+1 SHALL equal 12.
REQ-003 ACLK  input  1  clock; all logic on rising edge.
REQ-004 ARESET  input  1  reset, synchronous, active-high.
REQ-005 HF_FIFO_DOUT  input  192  first-word-fall-through (FWFT) header/footer entry: [191:128] header line 0, [127:64] header line 1, [63:0] footer.
REQ-006 HF_FIFO_EMPTY  input  1  HF FIFO has no entry; HF_FIFO_DOUT valid only when low.
REQ-007 HF_FIFO_RD_EN  output  1  pops current HF entry.
REQ-008 ADC_FIFO_DOUT  input  128  FWFT ADC word, 8 samples x 16 bit.
REQ-009 ADC_FIFO_EMPTY  input  1  ADC FIFO has no word.
REQ-010 ADC_FIFO_RD_EN  output  1  pops current ADC word.
REQ-011 M_AXIS_TDATA  output  64  dataframe line.
REQ-012 M_AXIS_TVALID  output  1  line valid.
REQ-013 M_AXIS_TREADY  input  1  downstream accepts.
REQ-014 M_AXIS_TLAST  output  1  marks footer line.
REQ-015 FRAME_COUNT  output  32  count of completed frames (footer accepted).
REQ-016 LEN_ERROR  output  1  sticky flag: odd frame length seen.

Function
REQ-017 States SHALL be IDLE, HDR0, HDR1, ADC_HI, ADC_LO, FTR; one line transferred per TVALID&TREADY beat.
REQ-018 IDLE with HF_FIFO_EMPTY=0: latch the 192-bit entry and length field, assert HF_FIFO_RD_EN for exactly that cycle, go to HDR0; TVALID=0 in IDLE.
REQ-019 HDR0/HDR1: TVALID=1, TDATA = latched header line 0/1; advance on beat.
REQ-020 Length L = latched 12-bit field = number of 64-bit ADC lines; remaining-line counter loaded with L[11:1]*2 on leaving IDLE.
REQ-021 From HDR1: if counter=0 go to FTR, else to ADC_HI.
REQ-022 ADC_HI: TVALID = !ADC_FIFO_EMPTY, TDATA = ADC_FIFO_DOUT[127:64]; on beat, counter-1, go to ADC_LO.
REQ-023 ADC_LO: TVALID = !ADC_FIFO_EMPTY, TDATA = ADC_FIFO_DOUT[63:0]; on beat, ADC_FIFO_RD_EN=1 same cycle, counter-1; go to FTR if counter was 1, else ADC_HI.
REQ-024 ADC_FIFO_RD_EN SHALL be asserted only in ADC_LO on a beat; never otherwise.
REQ-025 FTR: TVALID=1, TLAST=1, TDATA = latched footer; on beat FRAME_COUNT+1 (wraps 0xFFFFFFFF->0), return to IDLE.
REQ-026 TLAST SHALL be 0 in all states except FTR.
REQ-027 While TVALID=1 and TREADY=0, TDATA and TLAST SHALL remain stable (ADC FIFO is not popped, latched data unchanged).
REQ-028 ADC_FIFO_EMPTY mid-frame SHALL stall (TVALID=0) without state change; no timeout.
REQ-029 Odd L: LSB ignored (L-1 lines sent), LEN_ERROR set to 1 until ARESET.
REQ-030 Latency: HF entry present in IDLE cycle N -> header line 0 TVALID at cycle N+1; back-to-back frames lose exactly one IDLE cycle between footer beat and next header.
REQ-031 Frame on bus SHALL be exactly 2 + (L rounded down to even) + 1 lines.

Reset
REQ-032 ARESET=1 SHALL force state IDLE, TVALID=0, TLAST=0, TDATA=0, HF_FIFO_RD_EN=0, ADC_FIFO_RD_EN=0, FRAME_COUNT=0, LEN_ERROR=0, counter=0, latched entry=0.
REQ-033 ARESET mid-frame SHALL abandon the frame without TLAST; FIFO contents are not flushed by this block.
REQ-034 ARESET SHALL take priority over every other event in the same cycle.

Verification
REQ-035 One HF entry with L=4, ADC words A,B, TREADY=1 -> lines H0,H1,A[127:64],A[63:0],B[127:64],B[63:0],F on 7 consecutive cycles, TLAST only on F, FRAME_COUNT=1, 2 ADC pops, 1 HF pop.
REQ-036 L=0 -> H0,H1,F only; ADC_FIFO_RD_EN never asserted.
REQ-037 L=4 with TREADY toggling 1/0 each cycle and ADC_FIFO_EMPTY high for 3 cycles before B -> identical 7-line sequence, TDATA stable during every stall, no extra pops.
REQ-038 L=5 -> 4 ADC lines sent, LEN_ERROR=1, remains 1 across next valid frame.
REQ-039 ARESET asserted during ADC_LO of frame 1 -> next cycle TVALID=0, FRAME_COUNT=0; following frame from fresh FIFOs emitted correctly.
REQ-040 FRAME_COUNT forced near 0xFFFFFFFF, two frames -> wraps to 0x00000000 then 0x00000001.

Source files
------------

// File: rtl/dataframe_sequencer.sv
// Streams one dataframe per header/footer FIFO entry: two header lines, the
// ADC payload split into 64-bit halves, then a footer line marked with TLAST.
module dataframe_sequencer #(
    parameter int LEN_MSB = 175,
    parameter int LEN_LSB = 164
) (
    input  logic         ACLK,
    input  logic         ARESET,
    input  logic [191:0] HF_FIFO_DOUT,
    input  logic         HF_FIFO_EMPTY,
    output logic         HF_FIFO_RD_EN,
    input  logic [127:0] ADC_FIFO_DOUT,
    input  logic         ADC_FIFO_EMPTY,
    output logic         ADC_FIFO_RD_EN,
    output logic [63:0]  M_AXIS_TDATA,
    output logic         M_AXIS_TVALID,
    input  logic         M_AXIS_TREADY,
    output logic         M_AXIS_TLAST,
    output logic [31:0]  FRAME_COUNT,
    output logic         LEN_ERROR
);

    typedef enum logic [2:0] {IDLE, HDR0, HDR1, ADC_HI, ADC_LO, FTR} state_t;

    state_t        state_q, state_d;
    logic [191:0]  entry_q, entry_d;
    logic [11:0]   cnt_q, cnt_d;
    logic [31:0]   frame_count_q, frame_count_d;
    logic          len_error_q, len_error_d;
    logic [11:0]   len_field;

    assign len_field   = HF_FIFO_DOUT[LEN_MSB:LEN_LSB];
    assign FRAME_COUNT = frame_count_q;
    assign LEN_ERROR   = len_error_q;

    always_comb begin
        state_d        = state_q;
        entry_d        = entry_q;
        cnt_d          = cnt_q;
        frame_count_d  = frame_count_q;
        len_error_d    = len_error_q;
        HF_FIFO_RD_EN  = 1'b0;
        ADC_FIFO_RD_EN = 1'b0;
        M_AXIS_TVALID  = 1'b0;
        M_AXIS_TLAST   = 1'b0;
        M_AXIS_TDATA   = '0;

        case (state_q)
            IDLE: begin
                if (!HF_FIFO_EMPTY) begin
                    HF_FIFO_RD_EN = 1'b1;
                    entry_d       = HF_FIFO_DOUT;
                    // An odd length drops its LSB; only whole ADC words are sent.
                    cnt_d         = {len_field[11:1], 1'b0};
                    if (len_field[0]) begin
                        len_error_d = 1'b1;
                    end
                    state_d = HDR0;
                end
            end
            HDR0: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = entry_q[191:128];
                if (M_AXIS_TREADY) begin
                    state_d = HDR1;
                end
            end
            HDR1: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = entry_q[127:64];
                if (M_AXIS_TREADY) begin
                    state_d = (cnt_q == 12'd0) ? FTR : ADC_HI;
                end
            end
            ADC_HI: begin
                M_AXIS_TVALID = !ADC_FIFO_EMPTY;
                M_AXIS_TDATA  = ADC_FIFO_DOUT[127:64];
                if (!ADC_FIFO_EMPTY && M_AXIS_TREADY) begin
                    cnt_d   = cnt_q - 12'd1;
                    state_d = ADC_LO;
                end
            end
            ADC_LO: begin
                M_AXIS_TVALID = !ADC_FIFO_EMPTY;
                M_AXIS_TDATA  = ADC_FIFO_DOUT[63:0];
                if (!ADC_FIFO_EMPTY && M_AXIS_TREADY) begin
                    ADC_FIFO_RD_EN = 1'b1;
                    cnt_d          = cnt_q - 12'd1;
                    state_d        = (cnt_q == 12'd1) ? FTR : ADC_HI;
                end
            end
            FTR: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TLAST  = 1'b1;
                M_AXIS_TDATA  = entry_q[63:0];
                if (M_AXIS_TREADY) begin
                    frame_count_d = frame_count_q + 32'd1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset wins in its own cycle: nothing is popped or presented.
        if (ARESET) begin
            HF_FIFO_RD_EN  = 1'b0;
            ADC_FIFO_RD_EN = 1'b0;
            M_AXIS_TVALID  = 1'b0;
            M_AXIS_TLAST   = 1'b0;
            M_AXIS_TDATA   = '0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= IDLE;
            entry_q       <= '0;
            cnt_q         <= '0;
            frame_count_q <= '0;
            len_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            cnt_q         <= cnt_d;
            frame_count_q <= frame_count_d;
            len_error_q   <= len_error_d;
        end
    end

endmodule

// File: tb/tb_dataframe_sequencer.sv
// Directed bench for dataframe_sequencer: FWFT FIFO models feed the block and
// every accepted stream line is compared against hand-built frame contents.
module tb_dataframe_sequencer;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [191:0] HF_FIFO_DOUT;
    logic         HF_FIFO_EMPTY;
    logic         HF_FIFO_RD_EN;
    logic [127:0] ADC_FIFO_DOUT;
    logic         ADC_FIFO_EMPTY;
    logic         ADC_FIFO_RD_EN;
    logic [63:0]  M_AXIS_TDATA;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY;
    logic         M_AXIS_TLAST;
    logic [31:0]  FRAME_COUNT;
    logic         LEN_ERROR;

    always #5 ACLK = ~ACLK;

    dataframe_sequencer dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .HF_FIFO_DOUT  (HF_FIFO_DOUT),
        .HF_FIFO_EMPTY (HF_FIFO_EMPTY),
        .HF_FIFO_RD_EN (HF_FIFO_RD_EN),
        .ADC_FIFO_DOUT (ADC_FIFO_DOUT),
        .ADC_FIFO_EMPTY(ADC_FIFO_EMPTY),
        .ADC_FIFO_RD_EN(ADC_FIFO_RD_EN),
        .M_AXIS_TDATA  (M_AXIS_TDATA),
        .M_AXIS_TVALID (M_AXIS_TVALID),
        .M_AXIS_TREADY (M_AXIS_TREADY),
        .M_AXIS_TLAST  (M_AXIS_TLAST),
        .FRAME_COUNT   (FRAME_COUNT),
        .LEN_ERROR     (LEN_ERROR)
    );

    logic [191:0] hf_q[$];
    logic [127:0] adc_q[$];
    logic [64:0]  out_q[$];
    logic [64:0]  exp_q[$];
    logic [64:0]  prev_line;
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int hf_pops, adc_pops, first_cyc, last_cyc, hold_cnt, push_cyc;
    bit hold_arm, toggle_mode, stall_prev, last_seen;

    localparam logic [63:0]  H0 = 64'h1111_2222_3333_4444;
    localparam logic [63:0]  H1 = 64'h5555_6666_7777_8888;
    localparam logic [63:0]  FT = 64'hF00D_F00D_CAFE_0001;
    localparam logic [127:0] WA = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
    localparam logic [127:0] WB = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
    localparam logic [127:0] WC = 128'hC0C1_C2C3_C4C5_C6C7_C8C9_CACB_CCCD_CECF;
    localparam logic [127:0] WD = 128'hD0D1_D2D3_D4D5_D6D7_D8D9_DADB_DCDD_DEDF;

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic refresh();
        HF_FIFO_EMPTY  = (hf_q.size() == 0);
        HF_FIFO_DOUT   = (hf_q.size() != 0) ? hf_q[0] : '0;
        ADC_FIFO_EMPTY = (adc_q.size() == 0) || (hold_cnt > 0);
        ADC_FIFO_DOUT  = (adc_q.size() != 0) ? adc_q[0] : '0;
    endtask

    // One clock: observe outputs mid-cycle, then apply FIFO pops after the edge.
    task automatic tick();
        bit hf_rd, adc_rd;
        logic [64:0] line;
        @(negedge ACLK);
        hf_rd  = HF_FIFO_RD_EN;
        adc_rd = ADC_FIFO_RD_EN;
        line   = {M_AXIS_TLAST, M_AXIS_TDATA};
        if (stall_prev && M_AXIS_TVALID) check("stall_stable", line, prev_line);
        if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            out_q.push_back(line);
            if (out_q.size() == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (M_AXIS_TLAST) last_seen = 1'b1;
        end
        stall_prev = M_AXIS_TVALID && !M_AXIS_TREADY;
        prev_line  = line;
        hf_pops  += int'(hf_rd);
        adc_pops += int'(adc_rd);
        @(posedge ACLK);
        #1;
        cyc++;
        if (hold_cnt > 0) hold_cnt--;
        if (hf_rd && hf_q.size() != 0) void'(hf_q.pop_front());
        if (adc_rd && adc_q.size() != 0) begin
            void'(adc_q.pop_front());
            if (hold_arm) begin
                hold_arm = 1'b0;
                hold_cnt = 3;
            end
        end
        M_AXIS_TREADY = toggle_mode ? !M_AXIS_TREADY : 1'b1;
        refresh();
    endtask

    task automatic do_frame(input string tag, input logic [11:0] len, input int nw,
                            input logic [127:0] w0, input logic [127:0] w1,
                            input bit tog, input bit hold,
                            input logic [31:0] exp_fc, input bit exp_le);
        logic [191:0] e;
        logic [127:0] wd;
        int nl;
        e = {H0, H1, FT};
        e[175:164] = len;
        hf_q.push_back(e);
        if (nw > 0) adc_q.push_back(w0);
        if (nw > 1) adc_q.push_back(w1);
        exp_q.delete();
        exp_q.push_back({1'b0, e[191:128]});
        exp_q.push_back({1'b0, H1});
        nl = int'({len[11:1], 1'b0});
        for (int w = 0; w < nl / 2; w++) begin
            wd = (w == 0) ? w0 : w1;
            exp_q.push_back({1'b0, wd[127:64]});
            exp_q.push_back({1'b0, wd[63:0]});
        end
        exp_q.push_back({1'b1, FT});
        out_q.delete();
        hf_pops = 0; adc_pops = 0; last_seen = 1'b0;
        toggle_mode = tog; hold_arm = hold;
        push_cyc = cyc;
        refresh();
        for (int i = 0; i < 200 && !last_seen; i++) tick();
        check({tag, "_done"}, 96'(last_seen), 96'd1);
        repeat (3) tick();
        check({tag, "_nlines"}, 96'(out_q.size()), 96'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < out_q.size()) check($sformatf("%s_line%0d", tag, i), out_q[i], exp_q[i]);
        check({tag, "_adc_pops"}, 96'(adc_pops), 96'(nl / 2));
        check({tag, "_hf_pops"}, 96'(hf_pops), 96'd1);
        check({tag, "_fc"}, 96'(FRAME_COUNT), 96'(exp_fc));
        check({tag, "_lenerr"}, 96'(LEN_ERROR), 96'(exp_le));
        if (!tog && !hold) begin
            check({tag, "_latency"}, 96'(first_cyc - push_cyc), 96'd1);
            check({tag, "_span"}, 96'(last_cyc - first_cyc), 96'(exp_q.size() - 1));
        end
        toggle_mode   = 1'b0;
        M_AXIS_TREADY = 1'b1;
        stall_prev    = 1'b0;
    endtask

    initial begin
        logic [191:0] e;
        ARESET = 1'b1; M_AXIS_TREADY = 1'b1;
        toggle_mode = 0; hold_arm = 0; hold_cnt = 0; stall_prev = 0; last_seen = 0;
        hf_pops = 0; adc_pops = 0; prev_line = '0;
        hf_q.push_back({H0, H1, FT});
        refresh();
        repeat (3) tick();
        check("rst_tvalid", 96'(M_AXIS_TVALID), 96'd0);
        check("rst_tlast", 96'(M_AXIS_TLAST), 96'd0);
        check("rst_tdata", 96'(M_AXIS_TDATA), 96'd0);
        check("rst_hf_rd", 96'(HF_FIFO_RD_EN), 96'd0);
        check("rst_fc", 96'(FRAME_COUNT), 96'd0);
        check("rst_lenerr", 96'(LEN_ERROR), 96'd0);
        hf_q.delete();
        refresh();
        ARESET = 1'b0;
        tick();

        do_frame("l4", 12'd4, 2, WA, WB, 0, 0, 32'd1, 0);
        do_frame("l0", 12'd0, 0, WA, WB, 0, 0, 32'd2, 0);
        do_frame("l4stall", 12'd4, 2, WA, WB, 1, 1, 32'd3, 0);
        do_frame("l5", 12'd5, 2, WC, WD, 0, 0, 32'd4, 1);
        do_frame("l2sticky", 12'd2, 1, WD, WD, 0, 0, 32'd5, 1);

        // Reset while the first ADC low half is on the bus.
        e = {H0, H1, FT};
        e[175:164] = 12'd4;
        hf_q.push_back(e);
        adc_q.push_back(WA);
        adc_q.push_back(WB);
        out_q.delete(); last_seen = 1'b0; adc_pops = 0;
        refresh();
        for (int i = 0; i < 50 && out_q.size() < 3; i++) tick();
        check("midrst_reach", 96'(out_q.size()), 96'd3);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        hf_q.delete();
        adc_q.delete();
        refresh();
        check("midrst_tvalid", 96'(M_AXIS_TVALID), 96'd0);
        check("midrst_fc", 96'(FRAME_COUNT), 96'd0);
        check("midrst_lenerr", 96'(LEN_ERROR), 96'd0);
        check("midrst_no_tlast", 96'(last_seen), 96'd0);
        check("midrst_no_pop", 96'(adc_pops), 96'd0);
        tick();
        do_frame("postrst", 12'd2, 1, WC, WC, 0, 0, 32'd1, 0);

        force dut.frame_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.frame_count_q;
        do_frame("wrap0", 12'd0, 0, WA, WA, 0, 0, 32'h0000_0000, 0);
        do_frame("wrap1", 12'd0, 0, WA, WA, 0, 0, 32'h0000_0001, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
